// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, clock-count baud timer, mid-bit sampling,
// one-cycle byte-valid and framing-error strobes, debug view of the FSM state.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 rx_input_data,
  output logic                 rx,
  output logic [1:0]           rx_state,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_q, rx_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rx_q    <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic; sync2_q is the synchronized line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) state_d = S_START;
        else          state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) state_d = sync2_q ? S_IDLE : S_DATA;
        else                    state_d = S_START;
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST && idx_q == IDX_LAST) state_d = S_STOP;
        else                                         state_d = S_DATA;
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line idles so a break cannot re-trigger.
        if (brk_q)                              state_d = sync2_q ? S_IDLE : S_STOP;
        else if (cnt_q == BIT_LAST && sync2_q)  state_d = S_IDLE;
        else                                    state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, shift register, captured byte and strobes.
  always_comb begin
    sync1_d = rx_input_data;
    sync2_d = sync1_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rx_d    = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = brk_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        brk_d = 1'b0;
      end
      S_START: begin
        idx_d = '0;
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d                = shift_q >> 1;
          shift_d[DATA_BITS-1]   = sync2_q;
          cnt_d                  = '0;
          idx_d                  = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      S_STOP: begin
        if (brk_q) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          if (sync2_q) begin
            data_d = shift_q;
            rx_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
            cnt_d  = '0;
          end
        end else begin
          brk_d = brk_q;
        end
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_d;
  end

  assign rx           = rx_q;
  assign rx_state     = state_q;
  assign rx_data      = data_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: stimulus pushes expected frame outcomes, a negedge
// monitor pops and compares on every rx / rx_frame_err strobe.
module tb_uart_rx;
  localparam int CPB    = 4;
  localparam int DB     = 8;
  localparam int PERIOD = 1300;

  logic          clk = 1'b0;
  logic          nRST;
  logic          rx_pin;
  logic          rx;
  logic [1:0]    rx_state;
  logic [DB-1:0] rx_data;
  logic          rx_frame_err;

  typedef struct {
    bit           err;
    logic [DB-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  logic [DB-1:0] held = '0;
  int            checks = 0;
  int            fails  = 0;
  bit            trace_en = 1'b0;
  int            trace[$];
  bit            cnt01_en = 1'b0;
  int            st01_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .nRST(nRST), .rx_input_data(rx_pin), .rx(rx),
    .rx_state(rx_state), .rx_data(rx_data), .rx_frame_err(rx_frame_err)
  );

  always #20 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare strobes against the scoreboard, track held data and state trace.
  always @(negedge clk) begin
    ev_t e;
    if (nRST === 1'b0) begin
      check(!$isunknown({rx, rx_state, rx_data, rx_frame_err}), "no_x", {rx, rx_state, rx_frame_err}, 0);
      check(!(rx && rx_frame_err), "strobe_excl", {rx, rx_frame_err}, 0);
      if (rx || rx_frame_err) begin
        check(exp_q.size() != 0, "unexpected_strobe", {rx, rx_frame_err}, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(rx_frame_err == e.err, "event_kind", rx_frame_err, e.err);
          if (!e.err) held = e.data;
          check(rx_data == held, "rx_data", rx_data, held);
        end
      end else begin
        check(rx_data == held, "rx_data_hold", rx_data, held);
      end
      if (trace_en && (trace.size() == 0 || trace[$] != int'(rx_state))) trace.push_back(int'(rx_state));
      if (cnt01_en && rx_state == 2'b01) st01_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    rx_pin = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Reference: a frame outcome is decided purely by its data bits and stop bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    ev_t e;
    e.err  = !stop;
    e.data = d;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  function automatic logic stress_pin(input int t);
    if (t >= 20 * PERIOD) return 1'b1;
    return ((t % PERIOD) >= 300) ? 1'b1 : 1'b0;
  endfunction

  // Ideal mid-bit receiver over the periodic waveform.
  task automatic stress_expect();
    int   ready = 0;
    ev_t  e;
    int   s, stop_t;
    for (int p = 0; p < 20; p++) begin
      s = p * PERIOD;
      if (s >= ready && stress_pin(s + 80) == 1'b0) begin
        for (int k = 0; k < DB; k++) e.data[k] = stress_pin(s + 240 + 160 * k);
        stop_t = s + 240 + 160 * DB;
        e.err  = !stress_pin(stop_t);
        exp_q.push_back(e);
        ready = stop_t;
        if (e.err) ready = (stop_t / PERIOD) * PERIOD + 300;
      end
    end
  endtask

  initial begin
    int   exp_tr[5];
    bit   ok;
    logic [DB-1:0] d;
    bit   bad;

    exp_tr = '{0, 1, 2, 3, 0};
    nRST   = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(rx == 1'b0, "reset_rx", rx, 0);
    check(rx_state == 2'b00, "reset_state", rx_state, 0);
    check(rx_data == 8'h00, "reset_data", rx_data, 0);
    check(rx_frame_err == 1'b0, "reset_ferr", rx_frame_err, 0);
    @(posedge clk);
    #1 nRST = 1'b0;
    repeat (2) send_bit(1'b1);

    trace_en = 1'b1;
    send_frame(8'hA5, 1'b1);
    repeat (2) send_bit(1'b1);
    trace_en = 1'b0;
    ok = (trace.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) ok = ok && (trace[i] == exp_tr[i]);
    check(ok, "state_path", trace.size(), 5);

    st01_cnt = 0;
    cnt01_en = 1'b1;
    rx_pin = 1'b0;
    @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (10) @(posedge clk);
    #1 cnt01_en = 1'b0;
    check(st01_cnt == 2, "glitch_start_clks", st01_cnt, 2);
    check(rx_state == 2'b00, "glitch_idle", rx_state, 0);

    begin
      ev_t e;
      e.err = 1'b1;
      e.data = '0;
      exp_q.push_back(e);
    end
    rx_pin = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    check(rx_state == 2'b11, "break_hold_stop", rx_state, 3);
    @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    check(rx_state == 2'b00, "break_release", rx_state, 0);
    @(posedge clk);
    #1;

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    check(rx_state == 2'b10, "midframe_in_data", rx_state, 2);
    @(posedge clk);
    #1;
    nRST   = 1'b1;
    rx_pin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(rx_state == 2'b00, "midreset_state", rx_state, 0);
    check({rx, rx_frame_err} == 2'b00, "midreset_strobes", {rx, rx_frame_err}, 0);
    check(rx_data == 8'h00, "midreset_data", rx_data, 0);
    held = '0;
    @(posedge clk);
    #1 nRST = 1'b0;
    repeat (2) send_bit(1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (2) send_bit(1'b1);

    for (int n = 0; n < 30; n++) begin
      d   = DB'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end
    repeat (2) send_bit(1'b1);
    check(exp_q.size() == 0, "random_all_seen", exp_q.size(), 0);

    stress_expect();
    check(exp_q.size() == 10, "stress_expect_count", exp_q.size(), 10);
    repeat (20) begin
      rx_pin = 1'b0;
      #300;
      rx_pin = 1'b1;
      #1000;
    end
    repeat (20 * CPB) @(posedge clk);
    @(negedge clk);
    check(exp_q.size() == 0, "stress_all_seen", exp_q.size(), 0);
    check(rx_state == 2'b00, "stress_idle", rx_state, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
